vlan_input_arbiter: RTL and testbench
=====================================

// Module: vlan_input_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing one VLAN-processing pipeline (vlan remover) among
//  NUM_QUEUES input ports. Buffers each port in a small FIFO, grants one port at a time and forwards
//  whole packets (module headers + body) on the standard data/ctrl/wr/rdy bus. Never interleaves packets.
// PARAMETERS
//  DATA_WIDTH       64              bus data width
//  CTRL_WIDTH       DATA_WIDTH/8    bus ctrl width
//  NUM_QUEUES       4               number of requesting input ports, 2..8
//  FIFO_DEPTH_BITS  3               log2 depth of each per-port input FIFO
// PORTS
//  clk       in   1                          clock; single clock domain
//  reset     in   1                          asynchronous, active-high reset
//  in_data   in   NUM_QUEUES*DATA_WIDTH      port q data at [q*DATA_WIDTH +: DATA_WIDTH]
//  in_ctrl   in   NUM_QUEUES*CTRL_WIDTH      port q ctrl at [q*CTRL_WIDTH +: CTRL_WIDTH]
//  in_wr     in   NUM_QUEUES                 per-port write strobe
//  in_rdy    out  NUM_QUEUES                 per-port ready = !nearly_full of port FIFO
//  out_data  out  DATA_WIDTH                 registered data to VLAN pipeline
//  out_ctrl  out  CTRL_WIDTH                 registered ctrl to VLAN pipeline
//  out_wr    out  1                          registered write strobe
//  out_rdy   in   1                          downstream ready
//  pkt_cnt   out  NUM_QUEUES*32              per-port forwarded-packet count (only with ARB_PKT_CNT_EN)
// BEHAVIOUR
//  Reset (async): out_wr=0, out_data=0, out_ctrl=0, state=IDLE, rr_ptr=0, all FIFOs emptied, pkt_cnt=0.
//  Packet format: >=1 header word ctrl!=0, body words ctrl==0, last word ctrl!=0 (byte mask).
//  FSM (one-hot): IDLE, IN_HDRS, IN_BODY.
//   IDLE: pick first non-empty FIFO searching rr_ptr, rr_ptr+1, ... mod NUM_QUEUES; latch grant;
//         -> IN_HDRS. No word read in IDLE (1 bubble cycle between packets, fixed).
//   IN_HDRS: read when out_rdy && !empty[grant]; on word with ctrl==0 -> IN_BODY.
//   IN_BODY: read when out_rdy && !empty[grant]; on word with ctrl!=0 (EOP) -> IDLE,
//            rr_ptr <= (grant+1) mod NUM_QUEUES.
//  Read cycle: rd_en[grant]=1, next edge out_wr=1 with that word; latency 1 clk FIFO head -> out.
//  Non-read cycle: out_wr=0; out_data/out_ctrl hold last value.
//  out_rdy low or granted FIFO empty mid-packet: stall, hold grant; other ports never served mid-packet.
//  Writes into full FIFO are upstream's error; in_rdy deasserts at nearly_full (>=1 slot margin).
//  Simultaneous EOP read and new data on other ports: EOP cycle -> IDLE -> arbitrate next cycle.
//  Single requester: re-granted every packet (rr_ptr advances past it, search wraps back).
//  Reset mid-packet: packet truncated, FIFO contents discarded, no partial word emitted.
//  Words written to port q FIFO and read in same cycle are legal (FIFO handles simultaneity).
// CONFIGURATION
//  ARB_PKT_CNT_EN defined: pkt_cnt[q] increments by 1 on each EOP read for port q; 32-bit wrap to 0.
//  ARB_PKT_CNT_EN undefined: counters not built, pkt_cnt tied to 0.
// STRUCTURE
//  Shared defines file (onet_defines.v): arbiter state encodings, ARB_PKT_CNT_WIDTH=32.
//  Per-port FIFO: existing fallthrough_small_fifo, WIDTH=CTRL_WIDTH+DATA_WIDTH, MAX_DEPTH_BITS=FIFO_DEPTH_BITS.
//  Sub-module rr_grant_picker: combinational round-robin pick (req vector, rr_ptr -> grant idx, valid).
// TESTING
//  1. Port 0 only, pkt {hdr ctrl=FF, 3 body ctrl=0, last ctrl=0x80}, out_rdy=1 -> 5 words on out,
//     identical order/values, out_wr 1 clk after each read.
//  2. Ports 0..3 each queue one 4-word pkt at same cycle -> output order 0,1,2,3; no interleave;
//     1 idle cycle between packets.
//  3. Ports 1 and 3 each stream 3 pkts, rr_ptr=0 -> grant order 1,3,1,3,1,3.
//  4. out_rdy toggles 1,0,0,1 mid-body -> no reads/out_wr while low; word sequence unchanged.
//  5. Assert reset for 1 clk after 2nd word of a pkt -> out_wr=0 immediately, FIFOs empty,
//     fresh pkt on port 2 then forwarded intact starting from port 2.
//  6. ARB_PKT_CNT_EN: 5 pkts on port 0, 2 on port 3 -> pkt_cnt[0]=5, pkt_cnt[3]=2, others 0;
//     preload-free wrap check by forcing 32'hFFFF_FFFF then 1 pkt -> 0.

Source files
------------

// File: rtl/vlan_input_arbiter_pkg.sv
// Shared types and constants for the VLAN input arbiter slice.
// Holds the one-hot arbiter state encoding, counter width and round-robin helper.
package vlan_input_arbiter_pkg;

    localparam int ARB_PKT_CNT_WIDTH = 32;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'b001,
        ARB_IN_HDRS = 3'b010,
        ARB_IN_BODY = 3'b100
    } arb_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vlan_input_arbiter_if.sv
// Bundles the per-port input bus, the shared output bus and the packet counters.
// master = surrounding logic (upstream ports + VLAN pipeline), slave = the arbiter.
interface vlan_input_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_QUEUES = 4
);
    import vlan_input_arbiter_pkg::*;

    localparam int CTRL_WIDTH = DATA_WIDTH / 8;

    logic [NUM_QUEUES*DATA_WIDTH-1:0]        in_data;
    logic [NUM_QUEUES*CTRL_WIDTH-1:0]        in_ctrl;
    logic [NUM_QUEUES-1:0]                   in_wr;
    logic [NUM_QUEUES-1:0]                   in_rdy;
    logic [DATA_WIDTH-1:0]                   out_data;
    logic [CTRL_WIDTH-1:0]                   out_ctrl;
    logic                                    out_wr;
    logic                                    out_rdy;
    logic [NUM_QUEUES*ARB_PKT_CNT_WIDTH-1:0] pkt_cnt;

    modport master (
        output in_data, in_ctrl, in_wr, out_rdy,
        input  in_rdy, out_data, out_ctrl, out_wr, pkt_cnt
    );

    modport slave (
        input  in_data, in_ctrl, in_wr, out_rdy,
        output in_rdy, out_data, out_ctrl, out_wr, pkt_cnt
    );

endinterface

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: head word visible on dout while !empty.
// Latency: write visible at head the cycle after wr_en; read/write may coincide.
// Backpressure: nearly_full asserts at NEARLY_FULL entries; writes while full are dropped.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3,
    parameter int NEARLY_FULL    = (1 << MAX_DEPTH_BITS) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      full;
    logic                      wr_ok;
    logic                      rd_ok;

    assign full        = (depth == (MAX_DEPTH_BITS+1)'(DEPTH));
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(NEARLY_FULL));
    assign wr_ok       = wr_en && !full;
    assign rd_ok       = rd_en && !empty;
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

endmodule

// File: rtl/vlan_input_arbiter_rr_grant_picker.sv
// Round-robin pick: first requesting port starting at rr_ptr, wrapping modulo NUM_QUEUES.
// Latency: combinational.
// Backpressure: none; grant_vld low when no port requests.
module vlan_input_arbiter_rr_grant_picker #(
    parameter int NUM_QUEUES = 4,
    parameter int PTR_W      = 2
) (
    input  logic [NUM_QUEUES-1:0] req,
    input  logic [PTR_W-1:0]      rr_ptr,
    output logic [PTR_W-1:0]      grant_idx,
    output logic                  grant_vld
);
    int              cand;
    logic [PTR_W-1:0] cand_idx;

    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_QUEUES) cand = cand - NUM_QUEUES;
            cand_idx = PTR_W'(cand);
            if (!grant_vld && req[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/vlan_input_arbiter.sv
// Packet-granular round-robin arbiter feeding one VLAN pipeline; optional ARB_PKT_CNT_EN counters.
// Latency: 1 clk FIFO head -> out_wr; one idle cycle between packets for arbitration.
// Backpressure: out_rdy low or granted FIFO empty stalls mid-packet holding grant; in_rdy = !nearly_full.
module vlan_input_arbiter
    import vlan_input_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_QUEUES      = 4,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    vlan_input_arbiter_if.slave bus
);
    localparam int PTR_W  = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int FIFO_W = CTRL_WIDTH + DATA_WIDTH;

    arb_state_t            state;
    logic [PTR_W-1:0]      grant;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      pick_idx;
    logic                  pick_vld;
    logic [FIFO_W-1:0]     fifo_dout [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] fifo_empty;
    logic [NUM_QUEUES-1:0] fifo_nf;
    logic [NUM_QUEUES-1:0] fifo_rd;
    logic [FIFO_W-1:0]     head;
    logic [CTRL_WIDTH-1:0] head_ctrl;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  rd_fire;
    logic                  eop_fire;
    logic                  out_wr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_port
        fallthrough_small_fifo #(
            .WIDTH          (FIFO_W),
            .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .din         ({bus.in_ctrl[q*CTRL_WIDTH +: CTRL_WIDTH], bus.in_data[q*DATA_WIDTH +: DATA_WIDTH]}),
            .wr_en       (bus.in_wr[q]),
            .rd_en       (fifo_rd[q]),
            .dout        (fifo_dout[q]),
            .nearly_full (fifo_nf[q]),
            .empty       (fifo_empty[q])
        );
        assign bus.in_rdy[q] = !fifo_nf[q];
        assign fifo_rd[q]    = rd_fire && (grant == PTR_W'(q));
    end

    vlan_input_arbiter_rr_grant_picker #(
        .NUM_QUEUES (NUM_QUEUES),
        .PTR_W      (PTR_W)
    ) u_picker (
        .req       (~fifo_empty),
        .rr_ptr    (rr_ptr),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    assign head      = fifo_dout[grant];
    assign head_ctrl = head[FIFO_W-1 -: CTRL_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];
    assign rd_fire   = (state != ARB_IDLE) && bus.out_rdy && !fifo_empty[grant];
    assign eop_fire  = rd_fire && (state == ARB_IN_BODY) && (head_ctrl != '0);

    // IDLE never reads: the arbitration cycle is the fixed bubble between packets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            out_wr_q   <= 1'b0;
            out_data_q <= '0;
            out_ctrl_q <= '0;
        end else begin
            out_wr_q <= rd_fire;
            if (rd_fire) begin
                out_data_q <= head_data;
                out_ctrl_q <= head_ctrl;
            end
            case (state)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        grant <= pick_idx;
                        state <= ARB_IN_HDRS;
                    end
                end
                ARB_IN_HDRS: begin
                    if (rd_fire && head_ctrl == '0) state <= ARB_IN_BODY;
                end
                ARB_IN_BODY: begin
                    if (eop_fire) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= PTR_W'(rr_next(int'(grant), NUM_QUEUES));
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.out_wr   = out_wr_q;
    assign bus.out_data = out_data_q;
    assign bus.out_ctrl = out_ctrl_q;

`ifdef ARB_PKT_CNT_EN
    logic [NUM_QUEUES-1:0][ARB_PKT_CNT_WIDTH-1:0] pkt_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else if (eop_fire) begin
            pkt_cnt_q[grant] <= pkt_cnt_q[grant] + 1'b1;
        end
    end

    assign bus.pkt_cnt = pkt_cnt_q;
`else
    assign bus.pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_vlan_input_arbiter.sv
// Directed bench for vlan_input_arbiter: ordering, round-robin, stalls, reset and counters.
module tb_vlan_input_arbiter;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 4;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   rd_idx;

    logic [63:0] cap_d [$];
    logic [7:0]  cap_c [$];
    int          cap_t [$];
    int          first_drive_cyc;

    vlan_input_arbiter_if #(.DATA_WIDTH(DW), .NUM_QUEUES(NQ)) bus ();

    vlan_input_arbiter #(
        .DATA_WIDTH      (DW),
        .NUM_QUEUES      (NQ),
        .FIFO_DEPTH_BITS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && bus.out_wr) begin
            cap_d.push_back(bus.out_data);
            cap_c.push_back(bus.out_ctrl);
            cap_t.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] mk_data(input int q, input int p, input int k);
        return {8'(q), 8'hA5, 32'h0, 8'(p), 8'(k)};
    endfunction

    function automatic logic [7:0] mk_ctrl(input int k, input int len);
        if (k == 0) return 8'hFF;
        if (k == len - 1) return 8'h80;
        return 8'h00;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_d.delete();
        cap_c.delete();
        cap_t.delete();
        rd_idx = 0;
    endtask

    task automatic do_reset();
        bus.in_wr = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        clear_cap();
    endtask

    // Writes packet p (len words) into every port in mask, one word per cycle, honouring in_rdy.
    task automatic send_pkts(input logic [3:0] mask, input int p, input int len);
        int guard;
        for (int k = 0; k < len; k++) begin
            guard = 0;
            while ((bus.in_rdy & mask) != mask && guard < 200) begin
                bus.in_wr = '0;
                tick();
                guard++;
            end
            if (guard >= 200) chk("in_rdy_timeout", 128'(bus.in_rdy & mask), 128'(mask));
            if (k == 0) first_drive_cyc = cyc;
            for (int q = 0; q < NQ; q++) begin
                if (mask[q]) begin
                    bus.in_data[q*DW +: DW] = mk_data(q, p, k);
                    bus.in_ctrl[q*CW +: CW] = mk_ctrl(k, len);
                end
            end
            bus.in_wr = mask;
            tick();
        end
        bus.in_wr = '0;
    endtask

    task automatic wait_out(input string tag, input int n);
        int guard;
        guard = 0;
        while (cap_d.size() < n && guard < 1000) begin
            tick();
            guard++;
        end
        if (guard >= 1000) chk({tag, "_timeout"}, 128'(cap_d.size()), 128'(n));
        repeat (6) tick();
        chk({tag, "_count"}, 128'(cap_d.size()), 128'(n));
    endtask

    task automatic check_pkt(input string tag, input int q, input int p, input int len);
        for (int k = 0; k < len; k++) begin
            if (rd_idx < cap_d.size()) begin
                chk({tag, "_data"}, 128'(cap_d[rd_idx]), 128'(mk_data(q, p, k)));
                chk({tag, "_ctrl"}, 128'(cap_c[rd_idx]), 128'(mk_ctrl(k, len)));
            end else begin
                chk({tag, "_missing"}, 128'(cap_d.size()), 128'(rd_idx + 1));
            end
            rd_idx++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rd_idx   = 0;
        reset    = 1'b1;
        bus.in_wr   = '0;
        bus.in_data = '0;
        bus.in_ctrl = '0;
        bus.out_rdy = 1'b1;
        #1;
        chk("rst_out_wr", 128'(bus.out_wr), 128'(0));
        chk("rst_out_data", 128'(bus.out_data), 128'(0));
        chk("rst_out_ctrl", 128'(bus.out_ctrl), 128'(0));
        chk("rst_in_rdy", 128'(bus.in_rdy), 128'(4'hF));
        chk("rst_pkt_cnt", bus.pkt_cnt, 128'(0));
        do_reset();

        // Single port, single 5-word packet, streaming straight through.
        send_pkts(4'b0001, 0, 5);
        wait_out("t1", 5);
        check_pkt("t1", 0, 0, 5);
        if (cap_t.size() == 5) begin
            chk("t1_latency", 128'(cap_t[0]), 128'(first_drive_cyc + 3));
            for (int i = 1; i < 5; i++) chk("t1_back2back", 128'(cap_t[i] - cap_t[i-1]), 128'(1));
        end

        // All four ports at once: fair order 0..3 with one bubble between packets.
        do_reset();
        send_pkts(4'b1111, 0, 4);
        wait_out("t2", 16);
        for (int q = 0; q < 4; q++) check_pkt("t2", q, 0, 4);
        if (cap_t.size() == 16) begin
            for (int i = 1; i < 4; i++) chk("t2_gap", 128'(cap_t[4*i] - cap_t[4*i-1]), 128'(2));
        end

        // Ports 1 and 3 streaming: alternate grants.
        do_reset();
        for (int p = 0; p < 3; p++) send_pkts(4'b1010, p, 3);
        wait_out("t3", 18);
        for (int p = 0; p < 3; p++) begin
            check_pkt("t3_p1", 1, p, 3);
            check_pkt("t3_p3", 3, p, 3);
        end

        // out_rdy pattern 1,1,0,0,1... stalls mid-body without dropping or repeating words.
        do_reset();
        bus.out_rdy = 1'b0;
        send_pkts(4'b0001, 0, 6);
        repeat (2) tick();
        chk("t4_hold", 128'(cap_d.size()), 128'(0));
        begin
            logic [7:0] pat;
            pat = 8'b1111_0011;
            for (int i = 0; i < 8; i++) begin
                bus.out_rdy = pat[i];
                tick();
            end
        end
        bus.out_rdy = 1'b1;
        wait_out("t4", 6);
        check_pkt("t4", 0, 0, 6);
        if (cap_t.size() == 6) begin
            chk("t4_run", 128'(cap_t[1] - cap_t[0]), 128'(1));
            chk("t4_stall", 128'(cap_t[2] - cap_t[1]), 128'(3));
            chk("t4_resume", 128'(cap_t[3] - cap_t[2]), 128'(1));
        end

        // Reset mid-packet: output drops at once, queued words are discarded.
        do_reset();
        bus.out_rdy = 1'b0;
        send_pkts(4'b0010, 0, 5);
        clear_cap();
        bus.out_rdy = 1'b1;
        tick();
        tick();
        chk("t5_pre_out_wr", 128'(bus.out_wr), 128'(1));
        reset = 1'b1;
        #1;
        chk("t5_rst_out_wr", 128'(bus.out_wr), 128'(0));
        chk("t5_rst_out_data", 128'(bus.out_data), 128'(0));
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("t5_discarded", 128'(cap_d.size()), 128'(2));
        chk("t5_in_rdy", 128'(bus.in_rdy), 128'(4'hF));
        clear_cap();
        send_pkts(4'b0100, 1, 4);
        wait_out("t5", 4);
        check_pkt("t5", 2, 1, 4);

`ifdef ARB_PKT_CNT_EN
        do_reset();
        for (int p = 0; p < 5; p++) send_pkts(4'b0001, p, 3);
        for (int p = 0; p < 2; p++) send_pkts(4'b1000, p, 3);
        wait_out("t6", 21);
        chk("t6_cnt0", 128'(bus.pkt_cnt[31:0]), 128'(5));
        chk("t6_cnt12", 128'(bus.pkt_cnt[95:32]), 128'(0));
        chk("t6_cnt3", 128'(bus.pkt_cnt[127:96]), 128'(2));
        force dut.pkt_cnt_q[0] = 32'hFFFF_FFFF;
        tick();
        release dut.pkt_cnt_q[0];
        send_pkts(4'b0001, 9, 3);
        repeat (12) tick();
        chk("t6_wrap", 128'(bus.pkt_cnt[31:0]), 128'(0));
`else
        chk("t6_cnt_off", bus.pkt_cnt, 128'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
